// File: rtl/t5_pipectl.sv
// Pipeline hazard/stall controller: memory-wait, branch flush and load-use interlock.
// Produces stage enables, bubble/squash controls and a saturating stall-cycle counter.
module t5_pipectl #(
  parameter int unsigned XLEN = 32
) (
  input  logic        sclk,
  input  logic        srst_n,
  input  logic        iack,
  input  logic        dreq,
  input  logic        dack,
  input  logic [4:0]  drs1,
  input  logic [4:0]  drs2,
  input  logic [4:0]  xopc,
  input  logic [4:0]  xrd,
  input  logic        xbra,
  output logic        sena,
  output logic        fena,
  output logic        fnop,
  output logic        dnop,
  output logic [1:0]  state,
  output logic [15:0] scnt
);

  if (XLEN == 0) begin : gen_xlen_chk
    $error("XLEN must be nonzero");
  end

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StMwait  = 2'd1,
    StFlush  = 2'd2,
    StLstall = 2'd3
  } state_e;

  localparam logic [4:0] OpcLoad = 5'b00000;

  state_e      state_q, state_d;
  logic        fcnt_q, fcnt_d;
  logic [15:0] scnt_q, scnt_d;
  logic        mstall;
  logic        load_use;

  assign mstall   = dreq & ~dack;
  assign sena     = ~mstall;
  assign load_use = (xopc == OpcLoad) && (xrd != 5'd0) && ((xrd == drs1) || (xrd == drs2));

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    fena    = 1'b0;
    dnop    = 1'b0;
    fnop    = 1'b0;
    case (state_q)
      StRun: begin
        fena = iack & sena;
        dnop = ~iack;
        if (mstall) begin
          state_d = StMwait;
        end else if (xbra) begin
          state_d = StFlush;
          fcnt_d  = 1'b1;
        end else if (load_use) begin
          state_d = StLstall;
        end
      end
      StMwait: begin
        if (!mstall) state_d = StRun;
      end
      StFlush: begin
        fena = 1'b1;
        dnop = 1'b1;
        fnop = 1'b1;
        // A memory stall freezes the flush; only unstalled cycles consume fcnt.
        if (!mstall) begin
          if (fcnt_q == 1'b0) state_d = StRun;
          else                fcnt_d  = fcnt_q - 1'b1;
        end
      end
      StLstall: begin
        dnop = 1'b1;
        if (!mstall) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    scnt_d = scnt_q;
    if ((!sena || !fena) && (scnt_q != 16'hFFFF)) scnt_d = scnt_q + 16'd1;
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state_q <= StRun;
      fcnt_q  <= 1'b0;
      scnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  assign state = state_q;
  assign scnt  = scnt_q;

endmodule

// File: tb/tb_t5_pipectl.sv
// Self-checking bench for t5_pipectl: directed vector table, async-reset and saturation
// sequences, then randomized traffic against a rule-level reference model.
module tb_t5_pipectl;

  logic        sclk = 1'b0;
  logic        srst_n;
  logic        iack, dreq, dack, xbra;
  logic [4:0]  drs1, drs2, xopc, xrd;
  logic        sena, fena, fnop, dnop;
  logic [1:0]  state;
  logic [15:0] scnt;

  int checks = 0;
  int errors = 0;

  always #5 sclk = ~sclk;

  t5_pipectl #(.XLEN(32)) dut (
    .sclk   (sclk),
    .srst_n (srst_n),
    .iack   (iack),
    .dreq   (dreq),
    .dack   (dack),
    .drs1   (drs1),
    .drs2   (drs2),
    .xopc   (xopc),
    .xrd    (xrd),
    .xbra   (xbra),
    .sena   (sena),
    .fena   (fena),
    .fnop   (fnop),
    .dnop   (dnop),
    .state  (state),
    .scnt   (scnt)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        ia, dq, dk;
    logic [4:0]  rs1, rs2, op, rd;
    logic        br;
    logic [1:0]  st;
    logic        se, fe, fn, dn;
    logic [15:0] sc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string name, input logic rst, input logic ia, input logic dq,
                     input logic dk, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] op, input logic [4:0] rd, input logic br,
                     input logic [1:0] st, input logic se, input logic fe, input logic fn,
                     input logic dn, input logic [15:0] sc);
    vec_t v;
    v.name = name; v.rst = rst; v.ia = ia; v.dq = dq; v.dk = dk;
    v.rs1 = rs1; v.rs2 = rs2; v.op = op; v.rd = rd; v.br = br;
    v.st = st; v.se = se; v.fe = fe; v.fn = fn; v.dn = dn; v.sc = sc;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic ia, input logic dq, input logic dk, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] op, input logic [4:0] rd,
                       input logic br);
    iack = ia; dreq = dq; dack = dk; drs1 = rs1; drs2 = rs2; xopc = op; xrd = rd; xbra = br;
  endtask

  task automatic check(input string name, input logic [1:0] st, input logic se, input logic fe,
                       input logic fn, input logic dn, input logic [15:0] sc);
    logic [21:0] act, exp;
    act = {state, sena, fena, fnop, dnop, scnt};
    exp = {st, se, fe, fn, dn, sc};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got state=%0d sena=%b fena=%b fnop=%b dnop=%b scnt=%h, want state=%0d sena=%b fena=%b fnop=%b dnop=%b scnt=%h",
               name, state, sena, fena, fnop, dnop, scnt, st, se, fe, fn, dn, sc);
    end
  endtask

  // Reference model: mode number, remaining unstalled flush cycles, stall count.
  int m_st, m_left, m_sc;

  initial begin
    srst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'b01100, 5'd3, 1'b0);

    // Reset outputs, then steady-state run with no hazards.
    add("reset_outputs", 1, 0, 0, 0, 1, 2, 5'h0C, 3, 0, 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++)
      add("idle_run", 0, 1, 0, 0, 1, 2, 5'h0C, 3, 0, 0, 1, 1, 0, 0, 0);
    // Load-use on drs2.
    add("lu_detect",  0, 1, 0, 0, 1, 5, 5'h00, 5, 0, 0, 1, 1, 0, 0, 0);
    add("lu_lstall",  0, 1, 0, 0, 1, 2, 5'h0C, 3, 0, 3, 1, 0, 0, 1, 0);
    add("lu_resume",  0, 1, 0, 0, 1, 2, 5'h0C, 3, 0, 0, 1, 1, 0, 0, 1);
    // Load with xrd=0 is not a hazard.
    add("lu_x0",      0, 1, 0, 0, 0, 0, 5'h00, 0, 0, 0, 1, 1, 0, 0, 1);
    add("lu_x0_next", 0, 1, 0, 0, 1, 2, 5'h0C, 3, 0, 0, 1, 1, 0, 0, 1);
    // Branch flush, unstalled.
    add("br_take",    0, 1, 0, 0, 1, 2, 5'h0C, 3, 1, 0, 1, 1, 0, 0, 1);
    add("br_flush1",  0, 1, 0, 0, 1, 2, 5'h0C, 3, 1, 2, 1, 1, 1, 1, 1);
    add("br_flush2",  0, 1, 0, 0, 1, 2, 5'h0C, 3, 0, 2, 1, 1, 1, 1, 1);
    add("br_done",    0, 1, 0, 0, 1, 2, 5'h0C, 3, 0, 0, 1, 1, 0, 0, 1);
    // Branch flush stretched by a 3-cycle memory stall.
    add("fs_reset",   1, 0, 0, 0, 1, 2, 5'h0C, 3, 0, 0, 1, 0, 0, 1, 0);
    add("fs_take",    0, 1, 0, 0, 1, 2, 5'h0C, 3, 1, 0, 1, 1, 0, 0, 0);
    add("fs_stall1",  0, 1, 1, 0, 1, 2, 5'h0C, 3, 0, 2, 0, 1, 1, 1, 0);
    add("fs_stall2",  0, 1, 1, 0, 1, 2, 5'h0C, 3, 0, 2, 0, 1, 1, 1, 1);
    add("fs_stall3",  0, 1, 1, 0, 1, 2, 5'h0C, 3, 0, 2, 0, 1, 1, 1, 2);
    add("fs_flush1",  0, 1, 0, 0, 1, 2, 5'h0C, 3, 0, 2, 1, 1, 1, 1, 3);
    add("fs_flush2",  0, 1, 0, 0, 1, 2, 5'h0C, 3, 0, 2, 1, 1, 1, 1, 3);
    add("fs_done",    0, 1, 0, 0, 1, 2, 5'h0C, 3, 0, 0, 1, 1, 0, 0, 3);
    // Memory wait with a concurrent taken branch that must be ignored.
    add("mw_reset",   1, 0, 0, 0, 1, 2, 5'h0C, 3, 0, 0, 1, 0, 0, 1, 0);
    add("mw_start",   0, 1, 1, 0, 1, 2, 5'h0C, 3, 1, 0, 0, 0, 0, 0, 0);
    add("mw_wait1",   0, 1, 1, 0, 1, 2, 5'h0C, 3, 1, 1, 0, 0, 0, 0, 1);
    add("mw_wait2",   0, 1, 1, 0, 1, 2, 5'h0C, 3, 1, 1, 0, 0, 0, 0, 2);
    add("mw_wait3",   0, 1, 1, 0, 1, 2, 5'h0C, 3, 1, 1, 0, 0, 0, 0, 3);
    add("mw_dack",    0, 1, 1, 1, 1, 2, 5'h0C, 3, 1, 1, 1, 0, 0, 0, 4);
    add("mw_run",     0, 1, 0, 0, 1, 2, 5'h0C, 3, 0, 0, 1, 1, 0, 0, 5);
    add("mw_run2",    0, 1, 0, 0, 1, 2, 5'h0C, 3, 0, 0, 1, 1, 0, 0, 5);

    foreach (tbl[i]) begin
      @(negedge sclk);
      srst_n = ~tbl[i].rst;
      drive(tbl[i].ia, tbl[i].dq, tbl[i].dk, tbl[i].rs1, tbl[i].rs2, tbl[i].op, tbl[i].rd,
            tbl[i].br);
      #1 check(tbl[i].name, tbl[i].st, tbl[i].se, tbl[i].fe, tbl[i].fn, tbl[i].dn, tbl[i].sc);
    end

    // Asynchronous reset in the middle of a flush.
    @(negedge sclk);
    srst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'h0C, 5'd3, 1'b0);
    @(negedge sclk);
    srst_n = 1'b1;
    @(negedge sclk);
    @(negedge sclk);
    drive(1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'h0C, 5'd3, 1'b1);
    #1 check("ar_pre_branch", 0, 1, 1, 0, 0, 16'd2);
    @(negedge sclk);
    drive(1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'h0C, 5'd3, 1'b0);
    #1 check("ar_in_flush", 2, 1, 1, 1, 1, 16'd2);
    #2 srst_n = 1'b0;
    #1 check("ar_async_clear", 0, 1, 1, 0, 0, 16'd0);
    @(negedge sclk);
    srst_n = 1'b1;
    #1 check("ar_released", 0, 1, 1, 0, 0, 16'd0);
    @(negedge sclk);
    #1 check("ar_no_residual", 0, 1, 1, 0, 0, 16'd0);

    // Saturation of the stall counter.
    @(negedge sclk);
    srst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'h0C, 5'd3, 1'b0);
    @(negedge sclk);
    srst_n = 1'b1;
    repeat (65534) @(posedge sclk);
    @(negedge sclk);
    #1 check("sat_fffe", 0, 1, 0, 0, 1, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      @(negedge sclk);
      #1 check("sat_ffff", 0, 1, 0, 0, 1, 16'hFFFF);
    end

    // Randomized traffic against the reference model.
    m_st = 0; m_left = 0; m_sc = 0;
    @(negedge sclk);
    srst_n = 1'b0;
    @(negedge sclk);
    for (int c = 0; c < 3000; c++) begin
      logic rst, stall, lu, e_se, e_fe, e_fn, e_dn;
      if (c != 0) @(negedge sclk);
      rst    = ($urandom_range(99) == 0);
      srst_n = ~rst;
      drive($urandom_range(9) != 0, $urandom_range(9) < 3, $urandom_range(1) == 1,
            5'($urandom_range(3)), 5'($urandom_range(3)),
            ($urandom_range(2) == 0) ? 5'b00000 : 5'b01100, 5'($urandom_range(3)),
            $urandom_range(9) == 0);
      if (rst) begin
        m_st = 0; m_left = 0; m_sc = 0;
      end
      stall = dreq && !dack;
      e_se  = !stall;
      case (m_st)
        0:       begin e_fe = iack && e_se; e_dn = !iack; e_fn = 1'b0; end
        1:       begin e_fe = 1'b0; e_dn = 1'b0; e_fn = 1'b0; end
        2:       begin e_fe = 1'b1; e_dn = 1'b1; e_fn = 1'b1; end
        default: begin e_fe = 1'b0; e_dn = 1'b1; e_fn = 1'b0; end
      endcase
      #1 check("random", 2'(m_st), e_se, e_fe, e_fn, e_dn, 16'(m_sc));
      if (!rst) begin
        lu = (xopc == 5'd0) && (xrd != 5'd0) && (xrd == drs1 || xrd == drs2);
        if ((!e_se || !e_fe) && m_sc < 65535) m_sc = m_sc + 1;
        if (stall) begin
          if (m_st == 0) m_st = 1;
        end else begin
          case (m_st)
            0: begin
              if (xbra) begin m_st = 2; m_left = 2; end
              else if (lu) m_st = 3;
            end
            2: begin
              m_left = m_left - 1;
              if (m_left == 0) m_st = 0;
            end
            default: m_st = 0;
          endcase
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
